// File: rtl/db_multi_ctrl.sv
// Multi-channel switch debounce controller.
// A single free-running prescaler paces per-channel confirm counters. Each
// confirmed level change is posted to a per-channel pending flag. A
// round-robin arbiter then drains those flags into one valid/ready event slot.
module db_multi_ctrl #(
  parameter int NCH     = 4,
  parameter int TICK_W  = 19,
  parameter int CONFIRM = 3,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  sw,
  output logic [NCH-1:0]  db,
  output logic [NCH-1:0]  rise,
  output logic [NCH-1:0]  fall,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_edge,
  output logic            evt_ovf
);

  // CONFIRM is at most 7, so a 3-bit counter always covers 0..CONFIRM-1.
  localparam int CNT_W = 3;

  logic [NCH-1:0]            sync1_q, sync2_q;
  logic [TICK_W-1:0]         presc_q;
  logic                      tick;

  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]            db_q, db_d;
  logic [NCH-1:0]            accept;
  logic [NCH-1:0]            rise_q, fall_q;

  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            pend_edge_q, pend_edge_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]           evt_ch_q, evt_ch_d;
  logic                      evt_edge_q, evt_edge_d;
  logic                      ovf_q, ovf_d;
  logic [CH_W-1:0]           ptr_q, ptr_d;

  logic                      gnt_found;
  logic [CH_W-1:0]           gnt_idx;
  logic                      slot_load;

  // Two-flop synchroniser for the raw pads, plus the shared prescaler.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of block order.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      presc_q <= presc_q + TICK_W'(1);
    end
  end

  // Tick fires when the prescaler is 0, so the first one occurs right after reset.
  assign tick = (presc_q == '0);

  // Confirm counters: a new level must persist for CONFIRM ticks to be accepted.
  always_comb begin
    // NOTE: each variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    db_d   = db_q;
    accept = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_W'(CONFIRM - 1)) begin
          accept[i] = 1'b1;
          db_d[i]   = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level and single-cycle edge pulses, aligned with the db change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= accept & db_d;
      fall_q <= accept & ~db_d;
    end
  end

  // Round-robin search: find the first pending channel at or after ptr, wrapping.
  always_comb begin
    logic [CH_W:0] sum;
    logic [CH_W-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (sum >= (CH_W + 1)'(NCH)) begin
        sum = sum - (CH_W + 1)'(NCH);
      end
      idx = sum[CH_W-1:0];
      if (!gnt_found && pend_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // The slot may reload when it is empty or when its event is being accepted.
  assign slot_load = !evt_valid_q || evt_ready;

  // Slot loading, pending-flag bookkeeping and overflow detection.
  always_comb begin
    pend_d      = pend_q;
    pend_edge_d = pend_edge_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_edge_d  = evt_edge_q;
    ptr_d       = ptr_q;
    ovf_d       = ovf_q;

    if (slot_load) begin
      evt_valid_d = gnt_found;
      if (gnt_found) begin
        evt_ch_d        = gnt_idx;
        evt_edge_d      = pend_edge_q[gnt_idx];
        pend_d[gnt_idx] = 1'b0;
        ptr_d = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end

    // A grant in this cycle has already cleared pend_d, so an edge that
    // coincides with its own grant re-arms the flag without an overflow.
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        if (pend_d[i]) begin
          ovf_d = 1'b1;
        end
        pend_d[i]      = 1'b1;
        pend_edge_d[i] = db_d[i];
      end
    end
  end

  // Event slot, pending queue, round-robin pointer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      pend_edge_q <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_edge_q  <= 1'b0;
      ovf_q       <= 1'b0;
      ptr_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_edge_q <= pend_edge_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_edge_q  <= evt_edge_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
    end
  end

  assign db        = db_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_edge  = evt_edge_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_db_multi_ctrl.sv
// Self-checking bench for db_multi_ctrl (NCH=4, TICK_W=3, CONFIRM=3).
// The tick period is 8 cycles. Inputs are driven and outputs are sampled on the falling edge.
module tb_db_multi_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] db, rise, fall;
  logic       evt_valid, evt_ready, evt_edge, evt_ovf;
  logic [1:0] evt_ch;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] db;
    logic [1:0] ch;
    logic       pedge;
  } vec_t;

  vec_t vecs[6];

  db_multi_ctrl #(.NCH(4), .TICK_W(3), .CONFIRM(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .db        (db),
    .rise      (rise),
    .fall      (fall),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_edge  (evt_edge),
    .evt_ovf   (evt_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Poll each falling edge until db matches the target. The result is the number of edges waited, or 0 on timeout.
  task automatic wait_db(input logic [3:0] target, input int budget, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    for (int k = 1; k <= budget && !found; k++) begin
      @(negedge clk);
      if (db == target) begin
        found  = 1'b1;
        cycles = k;
      end
    end
    if (!found) check("wait_db_timeout", db, target);
  endtask

  task automatic next_evt(input string name, input logic [1:0] ch, input logic e);
    @(negedge clk);
    check({name, "_valid"}, evt_valid, 1);
    check({name, "_ch"}, evt_ch, ch);
    check({name, "_edge"}, evt_edge, e);
  endtask

  initial begin
    int k;
    int bad;
    logic [3:0] prev;

    //            sw        db        ch    edge
    vecs[0] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[1] = '{4'b0101, 4'b0101, 2'd0, 1'b1};
    vecs[2] = '{4'b1101, 4'b1101, 2'd3, 1'b1};
    vecs[3] = '{4'b1001, 4'b1001, 2'd2, 1'b0};
    vecs[4] = '{4'b1000, 4'b1000, 2'd0, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 2'd3, 1'b0};

    rst       = 1'b1;
    sw        = 4'b0000;
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_db", db, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_edge", evt_edge, 0);
    check("rst_ovf", evt_ovf, 0);
    rst = 1'b0;

    // Single-channel presses and releases. Each step checks latency, the pulse, and one event.
    for (int i = 0; i < 6; i++) begin
      prev = db;
      sw   = vecs[i].sw;
      wait_db(vecs[i].db, 40, k);
      check($sformatf("v%0d_lat_19_26", i), (k >= 19 && k <= 26) ? 32'd1 : 32'd0, 1);
      check($sformatf("v%0d_rise", i), rise, vecs[i].db & ~prev);
      check($sformatf("v%0d_fall", i), fall, ~vecs[i].db & prev);
      check($sformatf("v%0d_valid_early", i), evt_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_rise_off", i), rise, 0);
      check($sformatf("v%0d_fall_off", i), fall, 0);
      check($sformatf("v%0d_valid", i), evt_valid, 1);
      check($sformatf("v%0d_ch", i), evt_ch, vecs[i].ch);
      check($sformatf("v%0d_edge", i), evt_edge, vecs[i].pedge);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      check($sformatf("v%0d_drained", i), evt_valid, 0);
      repeat (3) @(negedge clk);
    end

    // Bounce on sw[1]: toggle every 5 cycles. Mismatch never spans two ticks.
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      sw[1] = (j % 2 == 0);
      repeat (5) begin
        @(negedge clk);
        if (db != 4'b0000 || rise != 4'b0000 || fall != 4'b0000 || evt_valid) bad++;
      end
    end
    sw[1] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (db != 4'b0000 || rise != 4'b0000 || fall != 4'b0000 || evt_valid) bad++;
    end
    check("bounce_quiet", bad, 0);

    // All four pressed together while the consumer stalls. The pointer is back at 0.
    sw = 4'b1111;
    wait_db(4'b1111, 40, k);
    check("multi_rise", rise, 4'b1111);
    next_evt("multi_first", 2'd0, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!evt_valid || evt_ch != 2'd0 || evt_edge != 1'b1) bad++;
    end
    check("multi_stall_stable", bad, 0);
    evt_ready = 1'b1;
    next_evt("multi_ch1", 2'd1, 1'b1);
    next_evt("multi_ch2", 2'd2, 1'b1);
    next_evt("multi_ch3", 2'd3, 1'b1);
    @(negedge clk);
    check("multi_empty", evt_valid, 0);

    sw = 4'b0000;
    wait_db(4'b0000, 40, k);
    next_evt("rel_ch0", 2'd0, 1'b0);
    next_evt("rel_ch1", 2'd1, 1'b0);
    next_evt("rel_ch2", 2'd2, 1'b0);
    next_evt("rel_ch3", 2'd3, 1'b0);
    @(negedge clk);
    check("rel_empty", evt_valid, 0);

    sw = 4'b1010;
    wait_db(4'b1010, 40, k);
    next_evt("pair_ch1", 2'd1, 1'b1);
    next_evt("pair_ch3", 2'd3, 1'b1);
    @(negedge clk);
    check("pair_empty", evt_valid, 0);
    sw = 4'b0000;
    wait_db(4'b0000, 40, k);
    next_evt("pair_rel_ch1", 2'd1, 1'b0);
    next_evt("pair_rel_ch3", 2'd3, 1'b0);
    @(negedge clk);
    evt_ready = 1'b0;

    // An edge lands in the same cycle as the grant of that channel's older pending event.
    sw = 4'b0001;
    wait_db(4'b0001, 40, k);
    sw = 4'b0000;
    next_evt("sim_press_slot", 2'd0, 1'b1);
    wait_db(4'b0000, 40, k);
    // The fall happened on a tick edge. The new rise is confirmed exactly 24 edges later.
    sw = 4'b0001;
    repeat (23) @(negedge clk);
    check("sim_db_before", db, 4'b0000);
    check("sim_slot_held", evt_edge, 1'b1);
    evt_ready = 1'b1;
    @(negedge clk);
    check("sim_rise", rise, 4'b0001);
    check("sim_valid", evt_valid, 1);
    check("sim_ch", evt_ch, 0);
    check("sim_old_edge", evt_edge, 1'b0);
    check("sim_no_ovf", evt_ovf, 0);
    next_evt("sim_new_edge", 2'd0, 1'b1);
    @(negedge clk);
    check("sim_empty", evt_valid, 0);
    check("sim_no_ovf_end", evt_ovf, 0);
    evt_ready = 1'b0;

    // Overflow: a second edge arrives while ch0 is still pending behind a stalled slot.
    evt_ready = 1'b1;
    sw = 4'b0000;
    wait_db(4'b0000, 40, k);
    next_evt("ovf_pre", 2'd0, 1'b0);
    @(negedge clk);
    check("ovf_pre_empty", evt_valid, 0);
    evt_ready = 1'b0;
    sw = 4'b0001;
    wait_db(4'b0001, 40, k);
    next_evt("ovf_press_slot", 2'd0, 1'b1);
    sw = 4'b0000;
    wait_db(4'b0000, 40, k);
    check("ovf_first_pending", evt_ovf, 0);
    sw = 4'b0001;
    wait_db(4'b0001, 40, k);
    check("ovf_set", evt_ovf, 1);
    sw = 4'b0000;
    wait_db(4'b0000, 40, k);
    check("ovf_sticky", evt_ovf, 1);
    check("ovf_slot_valid", evt_valid, 1);
    check("ovf_slot_edge", evt_edge, 1'b1);
    evt_ready = 1'b1;
    next_evt("ovf_release", 2'd0, 1'b0);
    @(negedge clk);
    check("ovf_empty", evt_valid, 0);
    check("ovf_still", evt_ovf, 1);
    evt_ready = 1'b0;

    // Asynchronous reset while ch3 holds the slot and ch2 has counted two ticks.
    sw = 4'b1000;
    wait_db(4'b1000, 40, k);
    sw = 4'b1100;
    next_evt("ar_slot", 2'd3, 1'b1);
    repeat (16) @(negedge clk);
    check("ar_db_pre", db, 4'b1000);
    #2 rst = 1'b1;
    #1;
    check("ar_db", db, 0);
    check("ar_valid", evt_valid, 0);
    check("ar_ch", evt_ch, 0);
    check("ar_edge", evt_edge, 0);
    check("ar_ovf", evt_ovf, 0);
    check("ar_rise_fall", {rise, fall}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Sync takes 2 edges and ticks fall on edges 1, 9, 17, 25, so acceptance comes on edge 25.
    wait_db(4'b1100, 40, k);
    check("ar_redebounce_lat", k, 25);
    check("ar_rise", rise, 4'b1100);
    evt_ready = 1'b1;
    next_evt("ar_evt_ch2", 2'd2, 1'b1);
    next_evt("ar_evt_ch3", 2'd3, 1'b1);
    @(negedge clk);
    check("ar_empty", evt_valid, 0);
    evt_ready = 1'b0;

    // Long steady run across several prescaler wraps.
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (db != 4'b1100 || rise != 4'b0000 || fall != 4'b0000 || evt_valid) bad++;
    end
    check("steady_run", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
